ram_d: RTL and testbench



---
 rtl/ram_d.sv | 66 ++++++
 tb/tb_ram_d.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ram_d.sv
// ram_d: single-clock simple dual-port RAM (one write port, one read port).
// The storage is cleared by an asynchronous active-low reset, and reads are
// registered. When a read and a write hit the same in-range address on the same
// edge, the read returns the word being written (write-first).
module ram_d #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Compare addresses one bit wider so that DEPTH == 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_next;

    // Range checks: out-of-range writes are dropped and out-of-range reads return zero.
    always_comb begin
        wr_ok = ({1'b0, wr_addr} < DEPTH_L);
        rd_ok = ({1'b0, rd_addr} < DEPTH_L);
    end

    // Select the read word, forwarding a same-address write so the read sees it.
    always_comb begin
        rd_next = '0;
        if (rd_ok) begin
            if (wr_en && wr_ok && (wr_addr == rd_addr)) begin
                rd_next = wr_data;
            end else begin
                rd_next = mem[rd_addr];
            end
        end
    end

    // Storage array, cleared on reset and updated by in-range enabled writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the output holds its value while rd_en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_ram_d.sv
// tb_ram_d: directed bench for ram_d. A word-level memory model follows the
// DUT on every cycle, and literal expectations pin the key cases.
module tb_ram_d;

    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int n_checks = 0;
    int n_fails  = 0;
    logic cmp_en = 1'b0;

    ram_d #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: contents as an array plus the last value a read returned.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rd;

    // Model update: the write lands first, so a same-edge read sees the new word.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] <= '0;
            model_rd <= '0;
        end else begin
            if (wr_en && (int'(wr_addr) < DEPTH)) model_mem[wr_addr] <= wr_data;
            if (rd_en) begin
                if (int'(rd_addr) >= DEPTH)
                    model_rd <= '0;
                else if (wr_en && wr_addr == rd_addr)
                    model_rd <= wr_data;
                else
                    model_rd <= model_mem[rd_addr];
            end
        end
    end

    // Compare the DUT output with the model in the middle of every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks++;
            if (rd_data !== model_rd) begin
                n_fails++;
                $display("FAIL model_cmp t=%0t rd_data=%h expected=%h", $time, rd_data, model_rd);
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] exp);
        n_checks++;
        if (rd_data !== exp) begin
            n_fails++;
            $display("FAIL %s t=%0t rd_data=%h expected=%h", name, $time, rd_data, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge and return 1 time unit after the posedge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        #1 rst = 1'b0;
        #1 check("reset_async", 8'h00);
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Reads after reset return zero.
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h4); check("rd_after_rst_4", 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h9); check("rd_after_rst_9", 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'hD); check("rd_after_rst_D", 8'h00);

        // Repeated writes of 0xAA to 0xF, then repeated reads.
        for (int i = 0; i < 10; i++) step(1'b1, 4'hF, 8'hAA, 1'b0, 4'h0);
        check("no_rd_hold", 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'h0, 8'h00, 1'b1, 4'hF);
            check("rd_F_AA", 8'hAA);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
            check("hold_AA", 8'hAA);
        end

        // Second location, and the first is left untouched.
        step(1'b1, 4'hC, 8'hAF, 1'b0, 4'h0);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'hC); check("rd_C_AF", 8'hAF);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'hF); check("rd_F_still_AA", 8'hAA);

        // Simultaneous access: same address (write-first) and different addresses.
        step(1'b1, 4'h3, 8'h55, 1'b1, 4'h3); check("wr_first_3", 8'h55);
        step(1'b1, 4'h4, 8'h66, 1'b1, 4'hF); check("indep_rd_F", 8'hAA);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h4); check("rd_4_66", 8'h66);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h3); check("rd_3_55", 8'h55);

        // A write with rd_en low leaves rd_data alone; the last write wins.
        step(1'b1, 4'h3, 8'h12, 1'b0, 4'h3); check("hold_during_wr", 8'h55);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h3); check("last_write_wins", 8'h12);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'hF); check("pre_reset_F", 8'hAA);

        // Reset between edges, with a write and a read in flight.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'h5; wr_data = 8'h77; rd_en = 1'b1; rd_addr = 4'hC;
        #2 rst = 1'b0;
        #1 check("mid_reset_async", 8'h00);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b1;

        step(1'b0, 4'h0, 8'h00, 1'b1, 4'hF); check("post_rst_F", 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'hC); check("post_rst_C", 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h3); check("post_rst_3", 8'h00);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h5); check("post_rst_lost_wr_5", 8'h00);
        step(1'b1, 4'h7, 8'h3C, 1'b0, 4'h0);
        step(1'b0, 4'h0, 8'h00, 1'b1, 4'h7); check("post_rst_wr_7", 8'h3C);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
